// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - Stall/flush control bundle between the pipeline and pipe_ctrl
//
// Purpose: groups the stall requests, exception requests and the resulting
// stall/flush controls into one interface.
// Modports:
//   master - pipeline side: drives requests, receives stall/flush controls
//   slave  - pipe_ctrl side: receives requests, drives stall/flush controls
// Signals:
//   stallreq_id/exe/mem  stage stall requests
//   exc_req, exc_eret    MEM-stage exception / ERET request
//   cp0_epc[31:0]        current EPC, used as ERET redirect target
//   stall[5:0]           per-stage stall vector (bit0 PC .. bit5 WB)
//   flush                single-cycle flush of all pipeline registers
//   flush_pc[31:0]       redirect PC while flush=1
//   exc_taken            registered copy of flush
//   busy                 pipeline is draining after a flush
// Optional (PIPE_CTRL_STALL_STAT_EN): stat_stall_cycles, stat_flush_count.

interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_exe;
  logic        stallreq_mem;
  logic        exc_req;
  logic        exc_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        exc_taken;
  logic        busy;
`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_flush_count;
`endif

  modport master (
    output stallreq_id, stallreq_exe, stallreq_mem, exc_req, exc_eret, cp0_epc,
`ifdef PIPE_CTRL_STALL_STAT_EN
    input  stat_stall_cycles, stat_flush_count,
`endif
    input  stall, flush, flush_pc, exc_taken, busy
  );

  modport slave (
    input  stallreq_id, stallreq_exe, stallreq_mem, exc_req, exc_eret, cp0_epc,
`ifdef PIPE_CTRL_STALL_STAT_EN
    output stat_stall_cycles, stat_flush_count,
`endif
    output stall, flush, flush_pc, exc_taken, busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Pipeline stall and flush controller for the five-stage MIPS32 core
//
// Purpose: converts ID/EXE/MEM stall requests into a per-stage stall vector,
// and MEM-stage exception/ERET requests into a one-cycle flush plus PC
// redirect. After a flush a drain FSM holds off further exceptions for
// DRAIN_CYCLES cycles while the pipeline refills.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_ctrl_if.slave (requests in, stall/flush controls out)
// Parameters:
//   EXC_VECTOR    exception redirect target
//   DRAIN_CYCLES  cycles spent in DRAIN after a flush (1..15)
// Optional feature macro: PIPE_CTRL_STALL_STAT_EN adds the free-running
// stall-cycle and flush-count statistics counters.

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        exc_taken_q, exc_taken_d;

  logic        exc_accept;
  logic [5:0]  stall_req_vec;
  logic [5:0]  stall_vec;
  logic [31:0] flush_pc_vec;

  // Highest requesting stage wins: stalling a stage also stalls everything
  // upstream of it.
  always_comb begin
    stall_req_vec = 6'b000000;
    if (bus.stallreq_mem) begin
      stall_req_vec = 6'b011111;
    end else if (bus.stallreq_exe) begin
      stall_req_vec = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_req_vec = 6'b000111;
    end
  end

  // Drain FSM. An exception is only accepted in IDLE and never while MEM is
  // waiting on the data bus, so the excepting instruction is not torn out of
  // a pending bus transaction.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exc_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_req && !bus.stallreq_mem) begin
          exc_accept = 1'b1;
          state_d    = ST_DRAIN;
          cnt_d      = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Flush overrides stall: the flushed registers must load bubbles, not hold.
  always_comb begin
    stall_vec    = exc_accept ? 6'b000000 : stall_req_vec;
    flush_pc_vec = 32'h0;
    if (exc_accept) begin
      flush_pc_vec = bus.exc_eret ? bus.cp0_epc : EXC_VECTOR;
    end
  end

  assign exc_taken_d = exc_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      exc_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exc_taken_q <= exc_taken_d;
    end
  end

  assign bus.stall     = stall_vec;
  assign bus.flush     = exc_accept;
  assign bus.flush_pc  = flush_pc_vec;
  assign bus.exc_taken = exc_taken_q;
  assign bus.busy      = (state_q == ST_DRAIN);

`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_flush_q, stat_flush_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_flush_d = stat_flush_q;
    if (stall_vec != 6'b000000) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
    if (exc_accept) begin
      stat_flush_d = stat_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= 32'd0;
      stat_flush_q <= 32'd0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign bus.stat_stall_cycles = stat_stall_q;
  assign bus.stat_flush_count  = stat_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - Self-checking bench for pipe_ctrl with a cycle-level reference model

module tb_pipe_ctrl;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam int          DRAIN   = 2;

  logic clk;
  logic rst_n;
  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR  (EXC_VEC),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining drain cycles, last cycle's flush, event counts.
  int          drain_left = 0;
  logic        prev_flush = 1'b0;
  logic        last_flush = 1'b0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic id, input logic exe, input logic mem,
                            input logic req, input logic eret, input logic [31:0] epc);
    bus.stallreq_id  = id;
    bus.stallreq_exe = exe;
    bus.stallreq_mem = mem;
    bus.exc_req      = req;
    bus.exc_eret     = eret;
    bus.cp0_epc      = epc;
  endtask

  // One clock cycle: apply inputs, check all outputs mid-cycle, then advance
  // the model across the rising edge.
  task automatic drive(input logic id, input logic exe, input logic mem,
                       input logic req, input logic eret, input logic [31:0] epc);
    logic        f_exp;
    logic [5:0]  s_exp;
    logic [31:0] pc_exp;
    int          depth;
    @(negedge clk);
    set_inputs(id, exe, mem, req, eret, epc);
    #1;
    f_exp  = (drain_left == 0) && req && !mem;
    depth  = mem ? 5 : (exe ? 4 : (id ? 3 : 0));
    s_exp  = f_exp ? 6'd0 : 6'((1 << depth) - 1);
    pc_exp = f_exp ? (eret ? epc : EXC_VEC) : 32'h0;
    check("stall",     32'(bus.stall),     32'(s_exp));
    check("flush",     32'(bus.flush),     32'(f_exp));
    check("flush_pc",  bus.flush_pc,       pc_exp);
    check("busy",      32'(bus.busy),      32'(drain_left > 0));
    check("exc_taken", 32'(bus.exc_taken), 32'(prev_flush));
`ifdef PIPE_CTRL_STALL_STAT_EN
    check("stat_stall", bus.stat_stall_cycles, m_stall_cnt);
    check("stat_flush", bus.stat_flush_count,  m_flush_cnt);
`endif
    @(posedge clk);
    prev_flush = f_exp;
    last_flush = f_exp;
    if (f_exp) drain_left = DRAIN;
    else if (drain_left > 0) drain_left--;
    if (s_exp != 6'd0) m_stall_cnt++;
    if (f_exp) m_flush_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0);
  endtask

  // Reset asserted at a falling edge; everything registered must clear at once.
  task automatic do_reset();
    @(negedge clk);
    set_inputs(0, 0, 0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    drain_left  = 0;
    prev_flush  = 1'b0;
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_exc_taken", 32'(bus.exc_taken), 32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_flush",     32'(bus.flush),     32'd0);
    check("rst_flush_pc",  bus.flush_pc,       32'h0);
`ifdef PIPE_CTRL_STALL_STAT_EN
    check("rst_stat_stall", bus.stat_stall_cycles, 32'd0);
    check("rst_stat_flush", bus.stat_flush_count,  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        pending;
    logic        p_eret;
    logic [31:0] p_epc;

    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 32'h0);
    #1;
    check("init_stall",     32'(bus.stall),     32'd0);
    check("init_flush",     32'(bus.flush),     32'd0);
    check("init_flush_pc",  bus.flush_pc,       32'h0);
    check("init_exc_taken", 32'(bus.exc_taken), 32'd0);
    check("init_busy",      32'(bus.busy),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet pipeline after reset release.
    idle(10);

    // Stall priority ladder.
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);
    drive(1, 1, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 0, 32'h0);
    drive(0, 0, 1, 0, 0, 32'h0);
    idle(1);

    // Exception in IDLE, request held through the drain window.
    drive(0, 0, 0, 1, 0, 32'h12345678);
    drive(0, 0, 0, 1, 0, 32'h12345678);
    drive(0, 1, 0, 1, 0, 32'h12345678);
    idle(3);

    // ERET blocked by MEM stall for 3 cycles, taken when the stall drops.
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1, 32'h80001234);
    drive(0, 0, 0, 1, 1, 32'h80001234);
    idle(3);

    // Exception alongside an EXE stall: flush wins.
    drive(0, 1, 0, 1, 0, 32'h0);
    idle(3);
    drive(1, 0, 0, 1, 1, 32'hA0000010);
    idle(3);

    // Reset in the middle of DRAIN, then a fresh exception is accepted.
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    do_reset();
    drive(0, 0, 0, 1, 1, 32'h8000BEEF);
    check("post_rst_accept", 32'(last_flush), 32'd1);
    idle(3);

`ifdef PIPE_CTRL_STALL_STAT_EN
    // 5 stalled cycles and 2 flushes from a clean reset.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);
    idle(DRAIN);
    drive(0, 0, 0, 1, 0, 32'h0);
    idle(DRAIN + 1);
    check("stat_stall_5", bus.stat_stall_cycles, 32'd5);
    check("stat_flush_2", bus.stat_flush_count,  32'd2);
`endif

    // Randomized traffic; an exception request is held until it is taken.
    pending = 1'b0;
    p_eret  = 1'b0;
    p_epc   = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic id, exe, mem;
      if (!pending && ($urandom_range(0, 5) == 0)) begin
        pending = 1'b1;
        p_eret  = 1'($urandom_range(0, 1));
        p_epc   = $urandom;
      end
      id  = ($urandom_range(0, 3) == 0);
      exe = ($urandom_range(0, 4) == 0);
      mem = ($urandom_range(0, 3) == 0);
      drive(id, exe, mem, pending, p_eret, p_epc);
      if (last_flush) pending = 1'b0;
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall and flush controller for the five-stage MIPS32 core. It takes stall requests from ID, EXE and MEM and turns them into a per-stage stall vector. It takes exception and ERET requests from the MEM stage and turns them into a single-cycle flush for every pipeline register, including the MEM/WB register, plus a PC redirect. A drain state machine blocks re-entry while the pipeline refills after a flush.

## Interface
- EXC_VECTOR, 32'hBFC00380: PC redirect target for exceptions.
- DRAIN_CYCLES, 2: cycles in DRAIN after a flush, legal range 1..15.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- stallreq_id  input  1  ID stall request (load-use hazard).
- stallreq_exe  input  1  EXE stall request (multi-cycle mul/div busy).
- stallreq_mem  input  1  MEM stall request (data bus not ready).
- exc_req  input  1  MEM stage holds an excepting instruction.
- exc_eret  input  1  MEM stage holds ERET; qualified by exc_req.
- cp0_epc  input  32  current CP0 EPC value.
- stall  output  6  stall vector: bit0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM, 5 WB.
- flush  output  1  flush to all pipeline registers.
- flush_pc  output  32  redirect PC, valid only while flush=1.
- exc_taken  output  1  registered pulse, one cycle after flush.
- busy  output  1  1 while the FSM is in DRAIN.

## Operation
- FSM states: IDLE, DRAIN. Reset state is IDLE.
- exc_accept = (state==IDLE) && exc_req && !stallreq_mem. An exception is never taken while MEM is waiting on the bus; exc_req must be held until accepted.
- flush = exc_accept. This is combinational in the same cycle.
- flush_pc = exc_eret ? cp0_epc : EXC_VECTOR when flush=1, else 32'h0.
- Stall vector (combinational, highest requesting stage wins):
  - stallreq_mem: 6'b011111
  - else stallreq_exe: 6'b001111
  - else stallreq_id: 6'b000111
  - else 6'b000000
- The downstream register of the highest stalled stage takes a bubble; the pipeline registers handle this, not pipe_ctrl.
- Flush overrides stall: stall=0 whenever flush=1.
- IDLE→DRAIN on exc_accept. A 4-bit counter loads DRAIN_CYCLES−1.
- In DRAIN:
  - exc_req is ignored and flush stays 0.
  - Stall requests still pass through normally.
  - The counter decrements each cycle; DRAIN→IDLE when the counter is 0.
- busy = (state==DRAIN).
- exc_taken is a registered copy of flush.

## Timing
- Reset values: stall=0, flush=0, flush_pc=0, exc_taken=0, busy=0, state=IDLE, counter=0.
- Reset asserted mid-DRAIN returns the FSM to IDLE immediately (asynchronous).
- stall, flush and flush_pc have zero latency from their inputs.
- exc_taken has one cycle of latency.
- busy is high for exactly DRAIN_CYCLES cycles, starting the cycle after flush.
- The earliest next flush is DRAIN_CYCLES+1 cycles after the previous flush.
- If exc_req and stallreq_mem are both high: no flush; stall=6'b011111. The flush happens in the first cycle stallreq_mem drops with exc_req still high.
- If exc_req and stallreq_exe/id are both high (with stallreq_mem low): flush=1, stall=0.
- ERET with exc_req high is treated as an exception that redirects to cp0_epc.

## Configuration
- Macro: PIPE_CTRL_STALL_STAT_EN.
- Defined: adds two outputs.
  - stat_stall_cycles, 32-bit: counts cycles with stall≠0.
  - stat_flush_count, 32-bit: counts flush pulses.
  - Both are free-running, wrap from 32'hFFFFFFFF to 0, and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with all requests low → stall=0, flush=0, busy=0 for 10 cycles.
- stallreq_id=1 → stall=6'h07. Add stallreq_exe=1 → 6'h0F. Add stallreq_mem=1 → 6'h1F, all in the same cycle.
- exc_req=1, exc_eret=0 in IDLE → flush=1 and flush_pc=32'hBFC00380 that cycle; exc_taken=1 next cycle; busy=1 for 2 cycles; exc_req held during busy → no second flush.
- exc_req=1, exc_eret=1, cp0_epc=32'h80001234 with stallreq_mem=1 for 3 cycles → flush=0 and stall=6'h1F for 3 cycles; flush=1 and flush_pc=32'h80001234 in the cycle stallreq_mem falls.
- exc_req with stallreq_exe=1 → flush=1 with stall=6'h00 that cycle.
- rst_n pulsed low during DRAIN → busy=0 immediately; a new exc_req after release is accepted. With PIPE_CTRL_STALL_STAT_EN defined: after 5 stalled cycles and 2 flushes, stat_stall_cycles=5 and stat_flush_count=2.
